// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle MIPS datapath: decodes opcode/funct
// and drives every write enable and mux select for each cycle of an instruction.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_we,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic       mem_addr_sel,
  output logic       mem_we,
  output logic       mdr_we,
  output logic       a_we,
  output logic       b_we,
  output logic       aluout_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] reg_in_sel,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_LWWB   = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BNE    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;

  assign state = state_q;

  // opcode/funct are captured in DECODE so later states ignore IR changes
  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    fn_d    = fn_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        fn_d = funct;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            case (funct)
              FN_JR:                  state_d = S_JR;
              FN_ADD, FN_SUB, FN_SLT: state_d = S_REXE;
              default:                state_d = S_FETCH;
            endcase
          end
          OP_XORI: state_d = S_IEXE;
          OP_BNE:  state_d = S_BNE;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_LWWB;
      S_REXE:   state_d = S_RWB;
      S_IEXE:   state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  // Moore decode; reset gates everything so an aborted instruction writes nothing
  always_comb begin
    ir_we        = 1'b0;
    pc_wren      = 1'b0;
    pc_src       = 2'b00;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    mdr_we       = 1'b0;
    a_we         = 1'b0;
    b_we         = 1'b0;
    aluout_we    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    ext_sel      = 1'b0;
    alu_op       = 3'b000;
    reg_we       = 1'b0;
    reg_dst      = 2'b00;
    reg_in_sel   = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_we     = 1'b1;
          pc_wren   = 1'b1;
          pc_src    = 2'b10;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          a_we      = 1'b1;
          b_we      = 1'b1;
          aluout_we = 1'b1;
          alu_src_b = 2'b11;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluout_we = 1'b1;
        end
        S_MEMRD: begin
          mem_addr_sel = 1'b1;
          mdr_we       = 1'b1;
        end
        S_LWWB: begin
          reg_we     = 1'b1;
          reg_in_sel = 2'b01;
        end
        S_MEMWR: begin
          mem_addr_sel = 1'b1;
          mem_we       = 1'b1;
        end
        S_REXE: begin
          alu_src_a = 1'b1;
          aluout_we = 1'b1;
          case (fn_q)
            FN_SUB:  alu_op = 3'b001;
            FN_SLT:  alu_op = 3'b011;
            default: alu_op = 3'b000;
          endcase
        end
        S_RWB: begin
          reg_we  = 1'b1;
          reg_dst = 2'b01;
        end
        S_IEXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_sel   = 1'b1;
          alu_op    = 3'b010;
          aluout_we = 1'b1;
        end
        S_IWB:  reg_we = 1'b1;
        S_BNE: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b001;
          pc_src    = 2'b01;
          pc_wren   = ~zero;
        end
        S_JUMP: begin
          pc_src  = 2'b11;
          pc_wren = 1'b1;
        end
        S_JAL: begin
          reg_we     = 1'b1;
          reg_dst    = 2'b10;
          reg_in_sel = 2'b10;
          pc_src     = 2'b11;
          pc_wren    = 1'b1;
        end
        S_JR: begin
          pc_src  = 2'b00;
          pc_wren = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: a per-instruction state-sequence
// model plus a per-state control table are compared against the DUT each cycle.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       ir_we;
    logic       pc_wren;
    logic [1:0] pc_src;
    logic       mem_addr_sel;
    logic       mem_we;
    logic       mdr_we;
    logic       a_we;
    logic       b_we;
    logic       aluout_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_op;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_in_sel;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       ir_we, pc_wren, mem_addr_sel, mem_we, mdr_we, a_we, b_we;
  logic       aluout_we, alu_src_a, ext_sel, reg_we;
  logic [1:0] pc_src, alu_src_b, reg_dst, reg_in_sel;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  int plan_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(ir_we), .pc_wren(pc_wren), .pc_src(pc_src), .mem_addr_sel(mem_addr_sel),
    .mem_we(mem_we), .mdr_we(mdr_we), .a_we(a_we), .b_we(b_we), .aluout_we(aluout_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel), .alu_op(alu_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .reg_in_sel(reg_in_sel), .state(state)
  );

  function automatic ctl_t observed();
    return '{ir_we, pc_wren, pc_src, mem_addr_sel, mem_we, mdr_we, a_we, b_we,
             aluout_we, alu_src_a, alu_src_b, ext_sel, alu_op, reg_we, reg_dst, reg_in_sel};
  endfunction

  // Visited states of one instruction, FETCH first; the next instruction restarts at FETCH.
  function automatic void build_plan(logic [5:0] op, logic [5:0] fn);
    plan_q = {0, 1};
    case (op)
      6'h23: plan_q = {0, 1, 2, 3, 4};
      6'h2B: plan_q = {0, 1, 2, 5};
      6'h0E: plan_q = {0, 1, 8, 9};
      6'h05: plan_q = {0, 1, 10};
      6'h02: plan_q = {0, 1, 11};
      6'h03: plan_q = {0, 1, 12};
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) plan_q = {0, 1, 6, 7};
        else if (fn == 6'h08) plan_q = {0, 1, 13};
      end
      default: ;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(int st, logic [5:0] fn, logic z);
    ctl_t c = '0;
    case (st)
      0:  begin c.ir_we = 1; c.pc_wren = 1; c.pc_src = 2'b10; c.alu_src_b = 2'b01; end
      1:  begin c.a_we = 1; c.b_we = 1; c.aluout_we = 1; c.alu_src_b = 2'b11; end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.aluout_we = 1; end
      3:  begin c.mem_addr_sel = 1; c.mdr_we = 1; end
      4:  begin c.reg_we = 1; c.reg_in_sel = 2'b01; end
      5:  begin c.mem_addr_sel = 1; c.mem_we = 1; end
      6:  begin
        c.alu_src_a = 1; c.aluout_we = 1;
        c.alu_op = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
      end
      7:  begin c.reg_we = 1; c.reg_dst = 2'b01; end
      8:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_sel = 1; c.alu_op = 3'b010; c.aluout_we = 1; end
      9:  c.reg_we = 1;
      10: begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01; c.pc_wren = !z; end
      11: begin c.pc_src = 2'b11; c.pc_wren = 1; end
      12: begin c.reg_we = 1; c.reg_dst = 2'b10; c.reg_in_sel = 2'b10; c.pc_src = 2'b11; c.pc_wren = 1; end
      13: c.pc_wren = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; runs n_states of the plan (-1 = all).
  task automatic run_instr(string name, logic [5:0] op, logic [5:0] fn, logic z, int n_states);
    int n;
    build_plan(op, fn);
    n = (n_states < 0) ? plan_q.size() : n_states;
    for (int i = 0; i < n; i++) begin
      opcode = (plan_q[i] == 1) ? op : 6'($urandom);
      funct  = (plan_q[i] == 1) ? fn : 6'($urandom);
      zero   = (plan_q[i] == 10) ? z : 1'($urandom);
      @(negedge clk);
      checks++;
      if (state !== 4'(plan_q[i])) begin
        failures++;
        $display("FAIL %s state step %0d: got %0d want %0d", name, i, state, plan_q[i]);
      end
      checks++;
      if (observed() !== expect_ctl(plan_q[i], fn, zero)) begin
        failures++;
        $display("FAIL %s ctl step %0d st %0d: got %h want %h", name, i, plan_q[i],
                 observed(), expect_ctl(plan_q[i], fn, zero));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_quiet(string name, int want_state);
    @(negedge clk);
    checks++;
    if (state !== 4'(want_state)) begin
      failures++;
      $display("FAIL %s state: got %0d want %0d", name, state, want_state);
    end
    checks++;
    if (observed() !== ctl_t'(0)) begin
      failures++;
      $display("FAIL %s ctl: got %h want 0", name, observed());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; opcode = 6'h23; funct = 6'h20; zero = 0;
    @(posedge clk); #1;
    check_reset_quiet("reset_idle", 0);
    check_reset_quiet("reset_hold", 0);
    reset = 0;
  endtask

  task automatic test_directed();
    run_instr("lw", 6'h23, 6'h00, 0, -1);
    run_instr("sw", 6'h2B, 6'h00, 0, -1);
    run_instr("j", 6'h02, 6'h00, 0, -1);
    run_instr("jal", 6'h03, 6'h00, 0, -1);
    run_instr("bne_z1", 6'h05, 6'h00, 1, -1);
    run_instr("bne_z0", 6'h05, 6'h00, 0, -1);
    run_instr("sub", 6'h00, 6'h22, 0, -1);
    run_instr("add", 6'h00, 6'h20, 0, -1);
    run_instr("slt", 6'h00, 6'h2A, 0, -1);
    run_instr("jr", 6'h00, 6'h08, 0, -1);
    run_instr("rtype_bad", 6'h00, 6'h3F, 0, -1);
    run_instr("xori", 6'h0E, 6'h00, 0, -1);
    run_instr("nop3f", 6'h3F, 6'h00, 0, -1);
  endtask

  task automatic test_reset_mid();
    run_instr("lw_abort", 6'h23, 6'h00, 0, 3);
    reset = 1;
    check_reset_quiet("abort_memrd", 3);
    check_reset_quiet("abort_after", 0);
    reset = 0;
    run_instr("after_abort", 6'h02, 6'h00, 0, -1);
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h05, 6'h0E, 6'h3F};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h11};
    logic [5:0] op, fn;
    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr("random", op, fn, 1'($urandom), -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
